// File: rtl/riscv_soft_decode_stage_pkg.sv
// Shared constants for the IF->ID decode stage: immediate-format selects, opcodes,
// reset NOP and the buffer occupancy states.
package riscv_soft_decode_stage_pkg;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   // Encoding is {main_valid, skid_valid}; 2'b01 can never occur.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } stage_state_t;

endpackage

// File: rtl/riscv_soft_decode_stage_imm_sel_decode.sv
// Combinational opcode decode: picks the immediate format for an instruction and
// flags opcodes that are not in the decode table.
module riscv_soft_imm_sel_decode
   import riscv_soft_decode_stage_pkg::*;
(
   input  logic [31:0] inst,
   output logic [2:0]  imm_sel,
   output logic        illegal
);

   logic [6:0] opcode;
   logic       unused_inst_hi;

   assign opcode         = inst[6:0];
   assign unused_inst_hi = ^inst[31:7];

   // Every table opcode ends in 2'b11, so compressed encodings fall into default.
   always_comb begin
      imm_sel = IMM_I;
      illegal = 1'b0;
      case (opcode)
         OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR,
         OPCODE_SYSTEM, OPCODE_MISC_MEM, OPCODE_OP: imm_sel = IMM_I;
         OPCODE_STORE:                              imm_sel = IMM_S;
         OPCODE_BRANCH:                             imm_sel = IMM_B;
         OPCODE_LUI, OPCODE_AUIPC:                  imm_sel = IMM_U;
         OPCODE_JAL:                                imm_sel = IMM_J;
         default:                                   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/riscv_soft_decode_stage.sv
// IF->ID boundary: 2-entry skid buffer carrying {inst, pc, imm_sel, illegal} with
// fully registered id_* outputs, 1 inst/cycle throughput and flush.
module riscv_soft_decode_stage
   import riscv_soft_decode_stage_pkg::*;
#(
   parameter int XPR_LEN = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic [31:0]        if_inst,
   input  logic [XPR_LEN-1:0] if_pc,
   input  logic               flush,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [31:0]        id_inst,
   output logic [XPR_LEN-1:0] id_pc,
   output logic [2:0]         id_imm_sel,
   output logic               id_illegal
);

   logic [2:0] in_imm_sel;
   logic       in_illegal;

   riscv_soft_imm_sel_decode u_imm_sel_decode (
      .inst    (if_inst),
      .imm_sel (in_imm_sel),
      .illegal (in_illegal)
   );

   stage_state_t state_reg;
   stage_state_t state_next;
   logic         load_main_in;
   logic         load_main_skid;
   logic         load_skid;
   logic         if_accept;
   logic         id_release;

   logic [31:0]        main_inst_reg;
   logic [XPR_LEN-1:0] main_pc_reg;
   logic [2:0]         main_imm_sel_reg;
   logic               main_illegal_reg;
   logic [31:0]        skid_inst_reg;
   logic [XPR_LEN-1:0] skid_pc_reg;
   logic [2:0]         skid_imm_sel_reg;
   logic               skid_illegal_reg;

   // if_ready depends on state only, keeping fetch free of any downstream comb path.
   assign if_ready   = (state_reg != ST_FULL);
   assign id_valid   = (state_reg != ST_EMPTY);
   assign if_accept  = if_valid & if_ready;
   assign id_release = id_valid & id_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (if_accept) begin
                  state_next   = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (if_accept && id_release) begin
                  load_main_in = 1'b1;
               end else if (if_accept) begin
                  state_next = ST_FULL;
                  load_skid  = 1'b1;
               end else if (id_release) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (id_release) begin
                  state_next     = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_inst_reg    <= INST_NOP;
         main_pc_reg      <= '0;
         main_imm_sel_reg <= IMM_I;
         main_illegal_reg <= 1'b0;
         skid_inst_reg    <= INST_NOP;
         skid_pc_reg      <= '0;
         skid_imm_sel_reg <= IMM_I;
         skid_illegal_reg <= 1'b0;
      end else begin
         if (load_skid) begin
            skid_inst_reg    <= if_inst;
            skid_pc_reg      <= if_pc;
            skid_imm_sel_reg <= in_imm_sel;
            skid_illegal_reg <= in_illegal;
         end
         if (load_main_in) begin
            main_inst_reg    <= if_inst;
            main_pc_reg      <= if_pc;
            main_imm_sel_reg <= in_imm_sel;
            main_illegal_reg <= in_illegal;
         end else if (load_main_skid) begin
            main_inst_reg    <= skid_inst_reg;
            main_pc_reg      <= skid_pc_reg;
            main_imm_sel_reg <= skid_imm_sel_reg;
            main_illegal_reg <= skid_illegal_reg;
         end
      end
   end

   assign id_inst    = main_inst_reg;
   assign id_pc      = main_pc_reg;
   assign id_imm_sel = main_imm_sel_reg;
   assign id_illegal = main_illegal_reg;

endmodule

// File: tb/tb_riscv_soft_decode_stage.sv
// Bench for riscv_soft_decode_stage: a 2-deep queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_riscv_soft_decode_stage;
   import riscv_soft_decode_stage_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [2:0]  id_imm_sel;
   logic        id_illegal;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  sel;
      logic        ill;
   } ent_t;

   ent_t exp_q[$];
   logic [6:0] ops[11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

   riscv_soft_decode_stage #(.XPR_LEN(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_inst    (if_inst),
      .if_pc      (if_pc),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_inst    (id_inst),
      .id_pc      (id_pc),
      .id_imm_sel (id_imm_sel),
      .id_illegal (id_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected decode straight from the opcode table.
   function automatic ent_t mk(input logic [31:0] inst, input logic [31:0] pc);
      ent_t e;
      logic [6:0] op;
      op    = inst[6:0];
      e.inst = inst;
      e.pc   = pc;
      e.sel  = IMM_I;
      e.ill  = 1'b0;
      if (op == 7'h23)                   e.sel = IMM_S;
      else if (op == 7'h63)              e.sel = IMM_B;
      else if (op inside {7'h37, 7'h17}) e.sel = IMM_U;
      else if (op == 7'h6F)              e.sel = IMM_J;
      else if (!(op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h33})) e.ill = 1'b1;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Queue model: pop the head on release, push on accept, clear on flush.
   task automatic model_step();
      bit acc;
      bit rel;
      acc = if_valid && (exp_q.size() < 2);
      rel = id_ready && (exp_q.size() != 0);
      if (flush) begin
         exp_q.delete();
      end else begin
         if (rel) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(mk(if_inst, if_pc));
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) exp_q.delete();
      else model_step();
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("cyc_if_ready", {31'd0, if_ready}, {31'd0, exp_q.size() < 2});
         chk("cyc_id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) begin
            chk("cyc_id_inst", id_inst, exp_q[0].inst);
            chk("cyc_id_pc", id_pc, exp_q[0].pc);
            chk("cyc_id_imm_sel", {29'd0, id_imm_sel}, {29'd0, exp_q[0].sel});
            chk("cyc_id_illegal", {31'd0, id_illegal}, {31'd0, exp_q[0].ill});
         end
      end
   end

   task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
      if_valid = v;
      if_inst  = inst;
      if_pc    = pc;
      id_ready = rdy;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input logic v, input logic [31:0] inst,
                          input logic [2:0] sel, input logic ill);
      chk({nm, "_valid"}, {31'd0, id_valid}, {31'd0, v});
      chk({nm, "_inst"}, id_inst, inst);
      chk({nm, "_sel"}, {29'd0, id_imm_sel}, {29'd0, sel});
      chk({nm, "_ill"}, {31'd0, id_illegal}, {31'd0, ill});
   endtask

   initial begin
      reset_n = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
      chk("rst_id_inst", id_inst, 32'h0000_0013);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_imm_sel", {29'd0, id_imm_sel}, {29'd0, IMM_I});
      chk("rst_illegal", {31'd0, id_illegal}, 32'd0);
      reset_n = 1'b1;

      // Streaming: addi then beq, one-cycle latency, id_valid continuous.
      set_in(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0); tick();
      chk_out("str_addi", 1'b1, 32'h0050_0093, IMM_I, 1'b0);
      chk("str_addi_pc", id_pc, 32'h100);
      set_in(1'b1, 32'hFE00_0EE3, 32'h104, 1'b1, 1'b0); tick();
      chk_out("str_beq", 1'b1, 32'hFE00_0EE3, IMM_B, 1'b0);
      chk("str_beq_pc", id_pc, 32'h104);
      set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
      chk("str_drain", {31'd0, id_valid}, 32'd0);

      // Backpressure: three back-to-back insts, released in order.
      set_in(1'b1, 32'h0010_0093, 32'h200, 1'b0, 1'b0); tick();
      chk_out("bp_c1", 1'b1, 32'h0010_0093, IMM_I, 1'b0);
      chk("bp_c1_rdy", {31'd0, if_ready}, 32'd1);
      set_in(1'b1, 32'h0011_2023, 32'h204, 1'b0, 1'b0); tick();
      chk_out("bp_c2", 1'b1, 32'h0010_0093, IMM_I, 1'b0);
      chk("bp_c2_rdy", {31'd0, if_ready}, 32'd0);
      set_in(1'b1, 32'h0000_006F, 32'h208, 1'b0, 1'b0); tick();
      chk_out("bp_c3", 1'b1, 32'h0010_0093, IMM_I, 1'b0);
      chk("bp_c3_pc", id_pc, 32'h200);
      set_in(1'b1, 32'h0000_006F, 32'h208, 1'b1, 1'b0); tick();
      chk_out("bp_r2", 1'b1, 32'h0011_2023, IMM_S, 1'b0);
      chk("bp_r2_pc", id_pc, 32'h204);
      set_in(1'b1, 32'h0000_006F, 32'h208, 1'b1, 1'b0); tick();
      chk_out("bp_r3", 1'b1, 32'h0000_006F, IMM_J, 1'b0);
      chk("bp_r3_pc", id_pc, 32'h208);
      set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
      chk("bp_drain", {31'd0, id_valid}, 32'd0);

      // Flush while FULL with a new inst offered.
      set_in(1'b1, 32'h0000_0013, 32'h300, 1'b0, 1'b0); tick();
      set_in(1'b1, 32'h0000_0093, 32'h304, 1'b0, 1'b0); tick();
      chk("fl_full_rdy", {31'd0, if_ready}, 32'd0);
      set_in(1'b1, 32'h0000_0113, 32'h308, 1'b0, 1'b1); tick();
      chk("fl_id_valid", {31'd0, id_valid}, 32'd0);
      chk("fl_if_ready", {31'd0, if_ready}, 32'd1);
      set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
      chk("fl_after", {31'd0, id_valid}, 32'd0);

      // Decode sweep.
      set_in(1'b1, 32'h1234_5037, 32'h400, 1'b1, 1'b0); tick();
      chk_out("dec_lui", 1'b1, 32'h1234_5037, IMM_U, 1'b0);
      set_in(1'b1, 32'h0000_006F, 32'h404, 1'b1, 1'b0); tick();
      chk_out("dec_jal", 1'b1, 32'h0000_006F, IMM_J, 1'b0);
      set_in(1'b1, 32'h0011_2023, 32'h408, 1'b1, 1'b0); tick();
      chk_out("dec_sw", 1'b1, 32'h0011_2023, IMM_S, 1'b0);
      set_in(1'b1, 32'h0000_007F, 32'h40C, 1'b1, 1'b0); tick();
      chk_out("dec_ill7f", 1'b1, 32'h0000_007F, IMM_I, 1'b1);
      set_in(1'b1, 32'h0000_0001, 32'h410, 1'b1, 1'b0); tick();
      chk_out("dec_ill01", 1'b1, 32'h0000_0001, IMM_I, 1'b1);
      set_in(1'b1, 32'h0000_0017, 32'h414, 1'b1, 1'b0); tick();
      chk_out("dec_auipc", 1'b1, 32'h0000_0017, IMM_U, 1'b0);

      // Asynchronous reset while FULL.
      set_in(1'b1, 32'h0000_0093, 32'h500, 1'b0, 1'b0); tick();
      set_in(1'b1, 32'h0000_0113, 32'h504, 1'b0, 1'b0); tick();
      reset_n = 1'b0;
      #1;
      chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("arst_if_ready", {31'd0, if_ready}, 32'd1);
      chk("arst_id_inst", id_inst, 32'h0000_0013);
      set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      chk("arst_after", {31'd0, id_valid}, 32'd0);

      // Random traffic against the queue model.
      for (int i = 0; i < 10000; i++) begin
         logic [31:0] r_inst;
         r_inst = $urandom;
         if ($urandom_range(0, 3) != 0) r_inst[6:0] = ops[$urandom_range(0, 10)];
         set_in($urandom_range(0, 3) != 0, r_inst, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
